// File: rtl/serial_byte_receiver_if.sv
// Signal bundle between the serial byte receiver, the line/strobe source and the word consumer.
// The master side is the receiver; the slave side drives the line and consumes words.
interface serial_byte_receiver_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  SerIn;
   logic                  BitStrobe;
   logic [DATA_WIDTH-1:0] DataOut;
   logic                  Valid;
   logic                  Ready;
   logic                  FrameErr;
   logic                  Overrun;
   logic                  ClearErr;
   logic                  Busy;

   modport master (
      input  SerIn, BitStrobe, Ready, ClearErr,
      output DataOut, Valid, FrameErr, Overrun, Busy
   );

   modport slave (
      output SerIn, BitStrobe, Ready, ClearErr,
      input  DataOut, Valid, FrameErr, Overrun, Busy
   );
endinterface

// File: rtl/serial_byte_receiver.sv
// Receives LSB-first framed serial bytes on an external bit strobe, buffers one word
// behind a valid/ready handshake and reports framing errors and overruns.
module serial_byte_receiver #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    Clk,
   input  logic                    Reset,
   serial_byte_receiver_if.master  rx
);
   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, DATA, STOP} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  ferr_q, ferr_d;
   logic                  ovr_q, ovr_d;

   logic stop_ok, stop_bad, buf_free, accept;

   assign stop_ok  = (state_q == STOP) && rx.BitStrobe && rx.SerIn;
   assign stop_bad = (state_q == STOP) && rx.BitStrobe && !rx.SerIn;
   assign accept   = valid_q && rx.Ready;
   assign buf_free = !valid_q || rx.Ready;

   always_ff @(posedge Clk) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (rx.BitStrobe) begin
         case (state_q)
            IDLE:    if (!rx.SerIn) state_d = DATA;
            DATA:    if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      ferr_d  = stop_bad;
      if (rx.BitStrobe) begin
         case (state_q)
            IDLE: if (!rx.SerIn) cnt_d = '0;
            DATA: begin
               shreg_d = {rx.SerIn, shreg_q[DATA_WIDTH-1:1]};
               cnt_d   = cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
      if (accept)   valid_d = 1'b0;
      if (rx.ClearErr) ovr_d = 1'b0;
      // Commit is evaluated after accept/clear so a same-cycle commit and overrun set win.
      if (stop_ok) begin
         if (buf_free) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      rx.Busy     = (state_q != IDLE);
      rx.DataOut  = data_q;
      rx.Valid    = valid_q;
      rx.FrameErr = ferr_q;
      rx.Overrun  = ovr_q;
   end
endmodule
